// File: rtl/sr_latch_writer_pkg.sv
// Shared types and sizing helpers for the SR latch write driver.
// Pure declarations: no latency, no backpressure.
package sr_latch_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SETTLE,
        CHECK
    } state_e;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter with a zero flag, shared by the PULSE and SETTLE phases.
// Load and decrement take effect at the next edge; zero is decoded from the count register.
module sr_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_writer.sv
// Turns a valid/ready one-bit write into a safe S/R/gate pulse sequence, then verifies Q/P and retries.
// One attempt takes 3+PULSE_CYCLES+SETTLE_CYCLES edges; WR_READY is low for the whole write.
module sr_latch_writer
    import sr_latch_writer_pkg::*;
#(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 3,
    parameter int RETRY_W       = width_for(MAX_RETRY)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_VALID,
    input  logic               WR_DATA,
    output logic               WR_READY,
    output logic               LAT_S,
    output logic               LAT_R,
    output logic               LAT_EN,
    input  logic               LAT_Q,
    input  logic               LAT_P,
    output logic               DONE,
    output logic               ERR,
    output logic               INVALID,
    output logic [RETRY_W-1:0] RETRY_CNT
);

    localparam int CNT_W = width_for((PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    state_e             state_q, state_d;
    logic               data_q, data_d;
    logic               ready_q, ready_d;
    logic               lat_s_q, lat_s_d;
    logic               lat_r_q, lat_r_d;
    logic               lat_en_q, lat_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               invalid_q, invalid_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic               tmr_dec;
    logic               tmr_zero;
    logic               check_pass;
    logic               drive_sr;

    sr_phase_timer #(
        .W (CNT_W)
    ) u_phase_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign check_pass = (LAT_Q == data_q) && (LAT_P == ~data_q);

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        retry_cnt_d  = retry_cnt_q;
        invalid_d    = invalid_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = PULSE_LOAD;
        tmr_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (WR_VALID) begin
                    data_d      = WR_DATA;
                    retry_cnt_d = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                tmr_load     = 1'b1;
                tmr_load_val = PULSE_LOAD;
                state_d      = PULSE;
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_d = HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HOLD: begin
                if (SETTLE_CYCLES > 0) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LOAD;
                    state_d      = SETTLE;
                end else begin
                    state_d = CHECK;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                if (LAT_Q == LAT_P) begin
                    invalid_d = 1'b1;
                end
                if (check_pass) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_cnt_q < RETRY_MAX) begin
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                    state_d     = SETUP;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Latch drives lag the state by one edge, so S/R bracket the gate on both sides.
        drive_sr = (state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD);
        lat_s_d  = drive_sr & data_q;
        lat_r_d  = drive_sr & ~data_q;
        lat_en_d = (state_q == PULSE);
        ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            data_q      <= 1'b0;
            ready_q     <= 1'b1;
            lat_s_q     <= 1'b0;
            lat_r_q     <= 1'b0;
            lat_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            invalid_q   <= 1'b0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            lat_s_q     <= lat_s_d;
            lat_r_q     <= lat_r_d;
            lat_en_q    <= lat_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            invalid_q   <= invalid_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign WR_READY  = ready_q;
    assign LAT_S     = lat_s_q;
    assign LAT_R     = lat_r_q;
    assign LAT_EN    = lat_en_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign INVALID   = invalid_q;
    assign RETRY_CNT = retry_cnt_q;

endmodule

// File: tb/tb_sr_latch_writer.sv
// Bench for sr_latch_writer: gated-NOR latch model with fault modes, directed writes,
// and a scoreboard of expected DONE/ERR events checked by an independent monitor.
module tb_sr_latch_writer;

    localparam int L = 6;  // 3 + PULSE_CYCLES(2) + SETTLE_CYCLES(1)

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_VALID = 1'b0;
    logic       WR_DATA = 1'b0;
    logic       WR_READY;
    logic       LAT_S, LAT_R, LAT_EN;
    logic       LAT_Q, LAT_P;
    logic       DONE, ERR, INVALID;
    logic [1:0] RETRY_CNT;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ev_cnt = 0;
    int mode = 0;  // 0 healthy, 1 stuck in reset state, 2 both outputs low
    logic mq = 1'b0;
    logic s_prev = 1'b0, r_prev = 1'b0, en_prev = 1'b0;

    typedef struct {
        bit is_err;
        int rcnt;
        int at;
        bit q;
    } exp_t;
    exp_t sb[$];

    sr_latch_writer dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_VALID  (WR_VALID),
        .WR_DATA   (WR_DATA),
        .WR_READY  (WR_READY),
        .LAT_S     (LAT_S),
        .LAT_R     (LAT_R),
        .LAT_EN    (LAT_EN),
        .LAT_Q     (LAT_Q),
        .LAT_P     (LAT_P),
        .DONE      (DONE),
        .ERR       (ERR),
        .INVALID   (INVALID),
        .RETRY_CNT (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (LAT_EN) begin
            if (LAT_S) mq <= 1'b1;
            else if (LAT_R) mq <= 1'b0;
        end
    end

    assign LAT_Q = (mode == 0) ? mq : 1'b0;
    assign LAT_P = (mode == 0) ? ~mq : (mode == 1) ? 1'b1 : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE/ERR must match the next scoreboard entry.
    always @(negedge CLK) begin
        exp_t e;
        if (DONE === 1'b1 || ERR === 1'b1) begin
            ev_cnt++;
            chk("done_err_exclusive", DONE & ERR, 0);
            if (sb.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("evt_kind_err", ERR, e.is_err);
                chk("evt_cycle", cyc, e.at);
                chk("evt_retry_cnt", RETRY_CNT, e.rcnt);
                if (!e.is_err) chk("evt_lat_q", LAT_Q, e.q);
            end
        end
        assert (!(LAT_S && LAT_R)) else begin
            bad++;
            $display("FAIL sr_overlap: S=%0b R=%0b at cycle %0d", LAT_S, LAT_R, cyc);
        end
        if (LAT_EN && en_prev) begin
            assert (LAT_S == s_prev && LAT_R == r_prev) else begin
                bad++;
                $display("FAIL sr_change_while_en: S=%0b R=%0b was S=%0b R=%0b", LAT_S, LAT_R, s_prev, r_prev);
            end
        end
        s_prev  = LAT_S;
        r_prev  = LAT_R;
        en_prev = LAT_EN;
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge e0.
    task automatic issue(input bit d, input int attempts, input bit is_err, input int rcnt, output int e0);
        int n = 0;
        while (WR_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        WR_VALID = 1'b1;
        WR_DATA  = d;
        e0 = cyc + 1;
        sb.push_back(exp_t'{is_err, rcnt, e0 + L * attempts, d});
        @(negedge CLK);
        WR_VALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, en_rises, base;
        logic en_last;
        bit seq[4];
        seq = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        RST = 1'b1;
        step(2);
        chk("rst_ready", WR_READY, 1);
        chk("rst_s", LAT_S, 0);
        chk("rst_r", LAT_R, 0);
        chk("rst_en", LAT_EN, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_invalid", INVALID, 0);
        chk("rst_retry", RETRY_CNT, 0);
        RST = 1'b0;
        step(1);

        // Write 1, healthy latch: cycle-by-cycle drive pattern
        issue(1'b1, 1, 1'b0, 0, e0);
        for (int k = 0; k <= L; k++) begin
            chk($sformatf("w1_s_k%0d", k), LAT_S, (k >= 1 && k <= 4));
            chk($sformatf("w1_r_k%0d", k), LAT_R, 0);
            chk($sformatf("w1_en_k%0d", k), LAT_EN, (k == 2 || k == 3));
            if (k < L) step(1);
        end
        chk("w1_done", DONE, 1);
        chk("w1_ready", WR_READY, 1);
        chk("w1_retry", RETRY_CNT, 0);
        chk("w1_q", LAT_Q, 1);
        step(1);
        chk("w1_done_one_cycle", DONE, 0);

        // Write 0, healthy latch
        issue(1'b0, 1, 1'b0, 0, e0);
        for (int k = 0; k <= L; k++) begin
            chk($sformatf("w0_r_k%0d", k), LAT_R, (k >= 1 && k <= 4));
            chk($sformatf("w0_s_k%0d", k), LAT_S, 0);
            if (k < L) step(1);
        end
        chk("w0_done", DONE, 1);
        chk("w0_q", LAT_Q, 0);
        chk("w0_p", LAT_P, 1);
        step(1);

        // Q stuck low: four attempts then ERR
        mode = 1;
        issue(1'b1, 4, 1'b1, 3, e0);
        en_rises = 0;
        en_last  = LAT_EN;
        for (int k = 1; k <= 4 * L; k++) begin
            step(1);
            if (LAT_EN && !en_last) en_rises++;
            en_last = LAT_EN;
            if (k == L) chk("stuck_retry_after_first", RETRY_CNT, 1);
            if (k < 4 * L) chk($sformatf("stuck_no_err_k%0d", k), ERR | DONE, 0);
        end
        chk("stuck_err", ERR, 1);
        chk("stuck_no_done", DONE, 0);
        chk("stuck_retry", RETRY_CNT, 3);
        chk("stuck_pulses", en_rises, 4);
        chk("stuck_invalid", INVALID, 0);
        step(1);
        chk("stuck_retry_hold", RETRY_CNT, 3);
        chk("stuck_err_one_cycle", ERR, 0);
        mode = 0;

        // Q==P at first check: INVALID sticks, retry succeeds
        mode = 2;
        issue(1'b1, 2, 1'b0, 1, e0);
        step(L);
        chk("inv_set", INVALID, 1);
        chk("inv_retry", RETRY_CNT, 1);
        mode = 0;
        step(L);
        chk("inv_retry_done", DONE, 1);
        step(1);
        issue(1'b0, 1, 1'b0, 0, e0);
        step(L);
        chk("inv_good_done", DONE, 1);
        chk("inv_sticky", INVALID, 1);
        step(1);

        // Reset during the second PULSE cycle
        issue(1'b1, 1, 1'b0, 0, e0);
        step(2);
        chk("abort_en_before", LAT_EN, 1);
        RST = 1'b1;
        sb.delete();
        step(1);
        chk("abort_en", LAT_EN, 0);
        chk("abort_s", LAT_S, 0);
        chk("abort_r", LAT_R, 0);
        chk("abort_ready", WR_READY, 1);
        chk("abort_invalid_clr", INVALID, 0);
        chk("abort_retry", RETRY_CNT, 0);
        RST = 1'b0;
        base = ev_cnt;
        step(10);
        chk("abort_no_events", ev_cnt - base, 0);

        // Back-to-back with WR_VALID held high and alternating data
        base = ev_cnt;
        WR_VALID = 1'b1;
        WR_DATA  = seq[0];
        e0 = cyc + 1;
        for (int i = 0; i < 4; i++) sb.push_back(exp_t'{1'b0, 0, e0 + (L + 1) * i + L, seq[i]});
        step(1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_busy_%0d", i), WR_READY, 0);
            if (i < 3) WR_DATA = seq[i+1];
            step(L);
            chk($sformatf("b2b_done_%0d", i), DONE, 1);
            chk($sformatf("b2b_ready_%0d", i), WR_READY, 1);
            if (i == 3) WR_VALID = 1'b0;
            else step(1);
        end
        step(10);
        chk("b2b_event_count", ev_cnt - base, 4);
        chk("b2b_idle_ready", WR_READY, 1);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
